// File: rtl/mouse_event_decoder.sv
// Mouse event decoder: grid block mapping, click/double-click/cheat detection, drag-and-drop FSM.
// Every output is registered and follows the sampled mouse inputs by one clk cycle.
module mouse_event_decoder #(
  parameter int unsigned X0       = 32,
  parameter int unsigned Y0       = 19,
  parameter int unsigned BLK_W    = 32,
  parameter int unsigned BLK_H    = 55,
  parameter int unsigned COLS     = 18,
  parameter int unsigned ROWS_TOP = 6,
  parameter int unsigned GAP      = 11,
  parameter int unsigned ROWS_BOT = 2,
  parameter int unsigned DBL_CYC  = 25_000_000,
  parameter int unsigned CHEAT_N  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic [9:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic       mouse_left,
  input  logic       mouse_right,
  output logic       mouse_inblock,
  output logic [4:0] mouse_block_x,
  output logic [2:0] mouse_block_y,
  output logic       l_click,
  output logic       r_click,
  output logic       dbl_click,
  output logic       cheat_activate,
  output logic       drag_active,
  output logic [4:0] drag_src_x,
  output logic [2:0] drag_src_y,
  output logic       drop_valid,
  output logic       drop_cancel,
  output logic [4:0] drop_x,
  output logic [2:0] drop_y
);

  localparam int unsigned X_END = X0 + COLS * BLK_W;
  localparam int unsigned YT_END = Y0 + ROWS_TOP * BLK_H;
  localparam int unsigned YB = YT_END + GAP;
  localparam int unsigned YB_END = YB + ROWS_BOT * BLK_H;
  localparam int CW = $clog2(CHEAT_N + 1);
  localparam int TW = $clog2(DBL_CYC + 1);
  localparam logic [CW-1:0] CHEAT_LAST = CW'(CHEAT_N - 1);
  localparam logic [TW-1:0] TMAX = TW'(DBL_CYC);

  typedef enum logic [1:0] {IDLE, HELD, DRAG} drag_state_e;

  logic rst_all;
  assign rst_all = rst | interboard_rst;

  logic [31:0] xu, yu;
  logic in_x, in_top, in_bot, in_d;
  logic [4:0] bx_d;
  logic [2:0] by_d;

  always_comb begin
    xu = 32'(mouse_x);
    yu = 32'(mouse_y);
    in_x = (xu >= X0) && (xu < X_END);
    in_top = (yu >= Y0) && (yu < YT_END);
    in_bot = (yu >= YB) && (yu < YB_END);
    in_d = 1'b0;
    bx_d = '0;
    by_d = '0;
    if (in_x && (in_top || in_bot)) begin
      in_d = 1'b1;
      bx_d = 5'((xu - X0) / BLK_W);
      by_d = in_top ? 3'((yu - Y0) / BLK_H) : 3'(ROWS_TOP + (yu - YB) / BLK_H);
    end
  end

  // mask_q blocks edges from a button still held when reset was released
  logic left_prev_q, right_prev_q, left_mask_q, right_mask_q;
  logic l_click_d, r_click_d;
  assign l_click_d = mouse_left & ~left_prev_q & ~left_mask_q;
  assign r_click_d = mouse_right & ~right_prev_q & ~right_mask_q;

  logic [CW-1:0] cnt_q, cnt_d;
  logic cheat_d;
  always_comb begin
    cnt_d = cnt_q;
    cheat_d = 1'b0;
    if (l_click_d) begin
      cnt_d = '0;
    end else if (r_click_d) begin
      if (cnt_q == CHEAT_LAST) begin
        cnt_d = '0;
        cheat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // timer_q holds the distance in cycles since the arming click
  logic armed_q, armed_d, dbl_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0] dbl_bx_q, dbl_bx_d;
  logic [2:0] dbl_by_q, dbl_by_d;
  always_comb begin
    armed_d = armed_q;
    timer_d = timer_q;
    dbl_bx_d = dbl_bx_q;
    dbl_by_d = dbl_by_q;
    dbl_d = 1'b0;
    if (armed_q) begin
      if (timer_q == TMAX) armed_d = 1'b0;
      else timer_d = timer_q + TW'(1);
    end
    if (l_click_d) begin
      if (armed_q && in_d && bx_d == dbl_bx_q && by_d == dbl_by_q) begin
        dbl_d = 1'b1;
        armed_d = 1'b0;
      end else if (in_d) begin
        armed_d = 1'b1;
        timer_d = TW'(1);
        dbl_bx_d = bx_d;
        dbl_by_d = by_d;
      end else begin
        armed_d = 1'b0;
      end
    end
  end

  logic inblock_q, l_click_q, r_click_q, dbl_q, cheat_q;
  logic [4:0] bx_q;
  logic [2:0] by_q;

  always_ff @(posedge clk) begin
    if (rst_all) begin
      left_prev_q <= 1'b0;
      right_prev_q <= 1'b0;
      left_mask_q <= 1'b1;
      right_mask_q <= 1'b1;
      inblock_q <= 1'b0;
      bx_q <= '0;
      by_q <= '0;
      l_click_q <= 1'b0;
      r_click_q <= 1'b0;
      dbl_q <= 1'b0;
      cheat_q <= 1'b0;
      cnt_q <= '0;
      armed_q <= 1'b0;
      timer_q <= '0;
      dbl_bx_q <= '0;
      dbl_by_q <= '0;
    end else begin
      left_prev_q <= mouse_left;
      right_prev_q <= mouse_right;
      left_mask_q <= left_mask_q & mouse_left;
      right_mask_q <= right_mask_q & mouse_right;
      inblock_q <= in_d;
      bx_q <= bx_d;
      by_q <= by_d;
      l_click_q <= l_click_d;
      r_click_q <= r_click_d;
      dbl_q <= dbl_d;
      cheat_q <= cheat_d;
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      timer_q <= timer_d;
      dbl_bx_q <= dbl_bx_d;
      dbl_by_q <= dbl_by_d;
    end
  end

  drag_state_e state_q;
  logic [4:0] src_x_q, drop_x_q;
  logic [2:0] src_y_q, drop_y_q;
  logic drop_valid_q, drop_cancel_q;

  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q <= IDLE;
      src_x_q <= '0;
      src_y_q <= '0;
      drop_valid_q <= 1'b0;
      drop_cancel_q <= 1'b0;
      drop_x_q <= '0;
      drop_y_q <= '0;
    end else begin
      drop_valid_q <= 1'b0;
      drop_cancel_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (l_click_d && in_d) begin
            state_q <= HELD;
            src_x_q <= bx_d;
            src_y_q <= by_d;
          end
        end
        HELD: begin
          if (!mouse_left) state_q <= IDLE;
          else if (in_d && (bx_d != src_x_q || by_d != src_y_q)) state_q <= DRAG;
        end
        DRAG: begin
          if (!mouse_left) begin
            state_q <= IDLE;
            if (in_d) begin
              drop_valid_q <= 1'b1;
              drop_x_q <= bx_d;
              drop_y_q <= by_d;
            end else begin
              drop_cancel_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mouse_inblock = inblock_q;
  assign mouse_block_x = bx_q;
  assign mouse_block_y = by_q;
  assign l_click = l_click_q;
  assign r_click = r_click_q;
  assign dbl_click = dbl_q;
  assign cheat_activate = cheat_q;
  assign drag_active = (state_q == DRAG);
  assign drag_src_x = src_x_q;
  assign drag_src_y = src_y_q;
  assign drop_valid = drop_valid_q;
  assign drop_cancel = drop_cancel_q;
  assign drop_x = drop_x_q;
  assign drop_y = drop_y_q;

endmodule

// File: tb/tb_mouse_event_decoder.sv
// Scoreboard bench for mouse_event_decoder: each cycle's expected outputs are queued with the
// stimulus and compared against the sampled outputs after the clock edge.
module tb_mouse_event_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, interboard_rst, mouse_left, mouse_right;
  logic [9:0] mouse_x;
  logic [8:0] mouse_y;
  logic mouse_inblock, l_click, r_click, dbl_click, cheat_activate, drag_active;
  logic drop_valid, drop_cancel;
  logic [4:0] mouse_block_x, drag_src_x, drop_x;
  logic [2:0] mouse_block_y, drag_src_y, drop_y;

  mouse_event_decoder #(.DBL_CYC(100)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left), .mouse_right(mouse_right),
    .mouse_inblock(mouse_inblock), .mouse_block_x(mouse_block_x), .mouse_block_y(mouse_block_y),
    .l_click(l_click), .r_click(r_click), .dbl_click(dbl_click), .cheat_activate(cheat_activate),
    .drag_active(drag_active), .drag_src_x(drag_src_x), .drag_src_y(drag_src_y),
    .drop_valid(drop_valid), .drop_cancel(drop_cancel), .drop_x(drop_x), .drop_y(drop_y)
  );

  typedef struct packed {
    logic inb; logic [4:0] bx; logic [2:0] by;
    logic l, r, dbl, cheat, dv, dc, da;
    logic [4:0] sx; logic [2:0] sy; logic [4:0] dx; logic [2:0] dy;
  } obs_t;
  typedef struct { obs_t v; obs_t m; string tag; } exp_t;

  localparam logic [6:0] PL = 7'h40, PR = 7'h20, PDBL = 7'h10, PCH = 7'h08;
  localparam logic [6:0] PDV = 7'h04, PDC = 7'h02, PDA = 7'h01;

  exp_t sb[$];
  obs_t got[$];
  int n_checks = 0;
  int n_fail = 0;
  obs_t m_blk, m_src, m_all;

  function automatic obs_t sample();
    obs_t o;
    o.inb = mouse_inblock; o.bx = mouse_block_x; o.by = mouse_block_y;
    {o.l, o.r, o.dbl, o.cheat, o.dv, o.dc, o.da} =
      {l_click, r_click, dbl_click, cheat_activate, drop_valid, drop_cancel, drag_active};
    o.sx = drag_src_x; o.sy = drag_src_y; o.dx = drop_x; o.dy = drop_y;
    return o;
  endfunction

  function automatic obs_t ev(bit inb, int bx, int by, logic [6:0] p,
                              int sx = 0, int sy = 0, int dx = 0, int dy = 0);
    obs_t o;
    o.inb = inb; o.bx = 5'(bx); o.by = 3'(by);
    {o.l, o.r, o.dbl, o.cheat, o.dv, o.dc, o.da} = p;
    o.sx = 5'(sx); o.sy = 3'(sy); o.dx = 5'(dx); o.dy = 3'(dy);
    return o;
  endfunction

  function automatic obs_t mk(bit blk, bit src, bit drop);
    obs_t o = '0;
    {o.l, o.r, o.dbl, o.cheat, o.dv, o.dc, o.da} = 7'h7f;
    if (blk) begin o.inb = 1'b1; o.bx = '1; o.by = '1; end
    if (src) begin o.sx = '1; o.sy = '1; end
    if (drop) begin o.dx = '1; o.dy = '1; end
    return o;
  endfunction

  task automatic put(int x, int y, bit l, bit r, obs_t v, obs_t m, string tag);
    mouse_x = 10'(x); mouse_y = 9'(y); mouse_left = l; mouse_right = r;
    sb.push_back('{v: v, m: m, tag: tag});
    @(posedge clk);
    @(negedge clk);
    got.push_back(sample());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) put(69, 79, 1, 1, ev(0, 0, 0, 0), m_all, "reset_state");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) put(69, 79, 1, 1, ev(1, 1, 1, 0), m_blk, "held_thru_reset");
    put(69, 79, 0, 0, ev(1, 1, 1, 0), m_blk, "release_after_reset");
    put(69, 79, 1, 1, ev(1, 1, 1, PL | PR), m_blk, "first_click_after_reset");
    put(69, 79, 1, 1, ev(1, 1, 1, 0, 1, 1), m_src, "src_latched");
    interboard_rst = 1'b1;
    put(69, 79, 1, 1, ev(0, 0, 0, 0), m_all, "interboard_reset");
    interboard_rst = 1'b0;
    put(69, 79, 0, 0, ev(1, 1, 1, 0), m_all, "after_interboard");
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  task automatic test_mapping();
    int xs[15] = '{32, 608, 607, 31, 100, 100, 100, 100, 100, 100, 100, 100, 639, 63, 64};
    int ys[15] = '{19, 19, 19, 19, 365, 352, 18, 348, 349, 360, 469, 470, 479, 73, 74};
    bit inb[15] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1};
    int bxs[15] = '{0, 0, 17, 0, 2, 0, 0, 2, 0, 2, 2, 0, 0, 0, 1};
    int bys[15] = '{0, 0, 0, 0, 6, 0, 0, 5, 0, 6, 7, 0, 0, 0, 1};
    for (int i = 0; i < 15; i++)
      put(xs[i], ys[i], 0, 0, ev(inb[i], bxs[i], bys[i], 0), m_blk, $sformatf("map_%0d_%0d", xs[i], ys[i]));
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  task automatic test_cheat();
    for (int i = 0; i < 5; i++) begin
      put(700, 0, 0, 1, ev(0, 0, 0, (i == 4) ? (PR | PCH) : PR), m_blk, "cheat_five");
      if (i == 0) put(700, 0, 0, 1, ev(0, 0, 0, 0), m_blk, "r_held_one_pulse");
      put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    end
    for (int i = 0; i < 4; i++) begin
      put(700, 0, 0, 1, ev(0, 0, 0, PR), m_blk, "cheat_pre_left");
      put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    end
    put(700, 0, 1, 0, ev(0, 0, 0, PL), m_blk, "cheat_left_clear");
    put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    for (int i = 0; i < 5; i++) begin
      put(700, 0, 0, 1, ev(0, 0, 0, (i == 4) ? (PR | PCH) : PR), m_blk, "cheat_after_clear");
      put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    end
    for (int i = 0; i < 3; i++) begin
      put(700, 0, 0, 1, ev(0, 0, 0, PR), m_blk, "cheat_pre_both");
      put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    end
    put(700, 0, 1, 1, ev(0, 0, 0, PL | PR), m_blk, "both_buttons");
    put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    for (int i = 0; i < 5; i++) begin
      put(700, 0, 0, 1, ev(0, 0, 0, (i == 4) ? (PR | PCH) : PR), m_blk, "cheat_after_both");
      put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "cheat_release");
    end
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  task automatic test_dbl_click();
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "dbl_arm");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    for (int i = 0; i < 8; i++) put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_wait10");
    put(133, 129, 1, 0, ev(1, 3, 2, PL | PDBL), m_blk, "dbl_10_apart");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "dbl_arm_again");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    for (int i = 0; i < 148; i++) put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_wait150");
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "no_dbl_150_apart");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    put(133, 129, 1, 0, ev(1, 3, 2, PL | PDBL), m_blk, "rearm_after_timeout");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "dbl_arm_3_2");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    put(165, 129, 1, 0, ev(1, 4, 2, PL), m_blk, "no_dbl_diff_block");
    put(165, 129, 0, 0, ev(1, 4, 2, 0), m_blk, "dbl_release");
    put(165, 129, 1, 0, ev(1, 4, 2, PL | PDBL), m_blk, "rearm_new_block");
    put(165, 129, 0, 0, ev(1, 4, 2, 0), m_blk, "dbl_release");
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "dbl_arm_before_out");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    put(700, 0, 1, 0, ev(0, 0, 0, PL), m_blk, "click_outside");
    put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "dbl_release");
    put(133, 129, 1, 0, ev(1, 3, 2, PL), m_blk, "no_dbl_after_disarm");
    put(133, 129, 0, 0, ev(1, 3, 2, 0), m_blk, "dbl_release");
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  task automatic test_drag();
    put(700, 0, 1, 0, ev(0, 0, 0, PL), m_blk, "press_outside");
    put(69, 79, 1, 0, ev(1, 1, 1, 0), m_blk, "outside_into_grid");
    put(165, 189, 1, 0, ev(1, 4, 3, 0), m_blk, "no_drag_from_outside");
    put(165, 189, 0, 0, ev(1, 4, 3, 0), m_blk, "release_idle");
    put(69, 79, 1, 0, ev(1, 1, 1, PL, 1, 1), m_src, "drag_press");
    put(80, 90, 1, 0, ev(1, 1, 1, 0, 1, 1), m_src, "same_block_held");
    put(165, 189, 1, 0, ev(1, 4, 3, PDA, 1, 1), m_src, "drag_start");
    put(165, 189, 1, 0, ev(1, 4, 3, PDA, 1, 1), m_src, "drag_hold");
    put(165, 189, 0, 0, ev(1, 4, 3, PDV, 1, 1, 4, 3), m_all, "drop_valid");
    put(165, 189, 0, 0, ev(1, 4, 3, 0, 1, 1, 4, 3), m_all, "drop_hold");
    put(40, 25, 1, 0, ev(1, 0, 0, PL, 0, 0, 4, 3), m_all, "held_press");
    put(40, 25, 0, 0, ev(1, 0, 0, 0, 0, 0, 4, 3), m_all, "held_release_no_drop");
    put(700, 0, 1, 0, ev(0, 0, 0, PL, 0, 0, 4, 3), m_all, "disarm_outside");
    put(700, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 4, 3), m_all, "release_idle");
    put(69, 79, 1, 0, ev(1, 1, 1, PL, 1, 1, 4, 3), m_all, "cancel_press");
    put(165, 189, 1, 0, ev(1, 4, 3, PDA, 1, 1, 4, 3), m_all, "cancel_drag");
    put(700, 189, 1, 0, ev(0, 0, 0, PDA, 1, 1, 4, 3), m_all, "drag_leave_grid");
    put(700, 189, 0, 0, ev(0, 0, 0, PDC, 1, 1, 4, 3), m_all, "drop_cancel");
    put(700, 189, 0, 0, ev(0, 0, 0, 0, 1, 1, 4, 3), m_all, "after_cancel");
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  task automatic test_reset_mid_drag();
    put(700, 0, 1, 0, ev(0, 0, 0, PL), m_blk, "disarm_outside");
    put(700, 0, 0, 0, ev(0, 0, 0, 0), m_blk, "release_idle");
    put(69, 79, 1, 0, ev(1, 1, 1, PL, 1, 1, 4, 3), m_all, "mid_press");
    put(165, 189, 1, 0, ev(1, 4, 3, PDA, 1, 1, 4, 3), m_all, "mid_drag");
    rst = 1'b1;
    put(165, 189, 1, 0, ev(0, 0, 0, 0), m_all, "reset_mid_drag");
    rst = 1'b0;
    put(165, 189, 1, 0, ev(1, 4, 3, 0), m_all, "held_after_reset");
    put(165, 189, 0, 0, ev(1, 4, 3, 0), m_all, "release_no_drop");
    put(165, 189, 1, 0, ev(1, 4, 3, PL, 4, 3), m_all, "click_after_reset");
    while (sb.size() > 0) begin
      exp_t e; obs_t o;
      e = sb.pop_front(); o = got.pop_front(); n_checks++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_fail++; $display("FAIL %s: got %h, required %h (mask %h)", e.tag, o & e.m, e.v & e.m, e.m);
      end
    end
  endtask

  initial begin
    m_blk = mk(1, 0, 0);
    m_src = mk(1, 1, 0);
    m_all = mk(1, 1, 1);
    rst = 1'b1; interboard_rst = 1'b0;
    mouse_x = '0; mouse_y = '0; mouse_left = 1'b0; mouse_right = 1'b0;
    @(negedge clk);
    test_reset();
    test_mapping();
    test_cheat();
    test_dbl_click();
    test_drag();
    test_reset_mid_drag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
